// File: rtl/soc_system_clkdiv_pkg.sv
// rtl/soc_system_clkdiv_pkg.sv - shared types and helpers for the multi-channel clock divider
package soc_system_clkdiv_pkg;

  // Counter width of the per-channel configuration fields
  localparam int CLKDIV_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, PEND, APPLY, SETTLE} ctrl_state_t;

  typedef enum logic [1:0] {PRE, HIGH, LOW} phase_t;

  typedef struct packed {
    logic                    en;
    logic [CLKDIV_CNT_W-1:0] prst;
    logic [CLKDIV_CNT_W-1:0] hi;
    logic [CLKDIV_CNT_W-1:0] lo;
  } chan_cfg_t;

  // Down-counter start value for a phase length; a length of 0 behaves as 1
  function automatic logic [CLKDIV_CNT_W-1:0] cnt_start(input logic [CLKDIV_CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CLKDIV_CNT_W'(1);
  endfunction

endpackage

// File: rtl/soc_system_clkdiv_chan.sv
// rtl/soc_system_clkdiv_chan.sv - one divider channel: PRE -> HIGH -> LOW phase engine
module soc_system_clkdiv_chan
  import soc_system_clkdiv_pkg::*;
#(
  parameter logic [CLKDIV_CNT_W-1:0] DEF_HI = 13,
  parameter logic [CLKDIV_CNT_W-1:0] DEF_LO = 12
) (
  input  logic      refclk,
  input  logic      rst_n,
  input  logic      load,
  input  chan_cfg_t load_cfg,
  output chan_cfg_t cfg_o,
  output logic      outclk,
  output logic      boundary
);

  chan_cfg_t               cfg_q, cfg_d;
  phase_t                  phase_q, phase_d;
  logic [CLKDIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                    out_q, out_d;

  // Next phase/count; a load restarts the channel, otherwise phases wrap with no dead cycle
  always_comb begin
    cfg_d   = cfg_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (load) begin
      cfg_d = load_cfg;
      if (!load_cfg.en) begin
        phase_d = LOW;
        cnt_d   = '0;
      end else if (load_cfg.prst != '0) begin
        phase_d = PRE;
        cnt_d   = load_cfg.prst - CLKDIV_CNT_W'(1);
      end else begin
        phase_d = HIGH;
        cnt_d   = cnt_start(load_cfg.hi);
      end
    end else if (cfg_q.en) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CLKDIV_CNT_W'(1);
      end else begin
        case (phase_q)
          HIGH: begin
            phase_d = LOW;
            cnt_d   = cnt_start(cfg_q.lo);
          end
          PRE, LOW: begin
            phase_d = HIGH;
            cnt_d   = cnt_start(cfg_q.hi);
          end
          default: begin
            phase_d = LOW;
            cnt_d   = '0;
          end
        endcase
      end
    end
    out_d = cfg_d.en && (phase_d == HIGH);
  end

  // State registers; the output bit is its own flop so it cannot glitch
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q   <= '{en: 1'b1, prst: '0, hi: DEF_HI, lo: DEF_LO};
      phase_q <= LOW;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign outclk   = out_q;
  assign cfg_o    = cfg_q;
  assign boundary = !cfg_q.en || ((phase_q == LOW) && (cnt_q == '0));

endmodule

// File: rtl/soc_system_clkdiv_multi.sv
// rtl/soc_system_clkdiv_multi.sv - multi-channel clock divider with reconfiguration FSM; readback under SOC_SYSTEM_CLKDIV_READBACK_EN
module soc_system_clkdiv_multi
  import soc_system_clkdiv_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEF_HI      = 13,
  parameter int DEF_LO      = 12,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                  refclk,
  input  logic                  rst_n,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic                  locked,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_chan,
  input  logic [CNT_W-1:0]      cfg_hi,
  input  logic [CNT_W-1:0]      cfg_lo,
  input  logic [CNT_W-1:0]      cfg_prst,
  input  logic                  cfg_en,
  output logic                  cfg_err,
  input  logic [3:0]            rd_chan,
  output logic [3*CNT_W:0]      rd_data
);

  localparam int SW = $clog2(LOCK_CYCLES) + 1;

  ctrl_state_t           state_q, state_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  locked_q, locked_d;
  logic                  err_q, err_d;
  logic [3:0]            req_chan_q, req_chan_d;
  chan_cfg_t             req_cfg_q, req_cfg_d;
  chan_cfg_t             act_cfg [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] boundary;
  logic [NUM_CLOCKS-1:0] load;
  logic                  sel_boundary;

  // Boundary of the requested channel and the load strobe that fires on it
  always_comb begin
    sel_boundary = 1'b0;
    load         = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (req_chan_q == 4'(i)) begin
        sel_boundary = boundary[i];
        load[i]      = (state_q == PEND) && boundary[i];
      end
    end
  end

  // Control FSM: accept, wait for the period boundary, apply, then settle before locking
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    locked_d   = locked_q;
    err_d      = 1'b0;
    req_chan_d = req_chan_q;
    req_cfg_d  = req_cfg_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          req_chan_d = cfg_chan;
          req_cfg_d  = '{en: cfg_en, prst: cfg_prst, hi: cfg_hi, lo: cfg_lo};
          if ({1'b0, cfg_chan} < 5'(NUM_CLOCKS)) state_d = PEND;
          else                                   err_d   = 1'b1;
        end
      end
      PEND: begin
        if (sel_boundary) begin
          state_d  = APPLY;
          locked_d = 1'b0;
        end
      end
      APPLY: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        if (settle_q == SW'(LOCK_CYCLES - 1)) begin
          locked_d = 1'b1;
          state_d  = IDLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  // Control registers
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      settle_q   <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      req_chan_q <= '0;
      req_cfg_q  <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      req_chan_q <= req_chan_d;
      req_cfg_q  <= req_cfg_d;
    end
  end

  assign locked    = locked_q;
  assign cfg_err   = err_q;
  assign cfg_ready = (state_q == IDLE);

  for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_chan
    soc_system_clkdiv_chan #(
      .DEF_HI(CLKDIV_CNT_W'(DEF_HI)),
      .DEF_LO(CLKDIV_CNT_W'(DEF_LO))
    ) u_chan (
      .refclk  (refclk),
      .rst_n   (rst_n),
      .load    (load[g]),
      .load_cfg(req_cfg_q),
      .cfg_o   (act_cfg[g]),
      .outclk  (outclk[g]),
      .boundary(boundary[g])
    );
  end

`ifdef SOC_SYSTEM_CLKDIV_READBACK_EN
  // Readback of the active configuration; out-of-range selects return zero
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (rd_chan == 4'(i)) rd_data = act_cfg[i];
    end
  end
`else
  logic unused_rd_acc;

  // Readback removed: fold the otherwise unread signals into one unused bit
  always_comb begin
    unused_rd_acc = ^rd_chan;
    for (int i = 0; i < NUM_CLOCKS; i++) unused_rd_acc = unused_rd_acc ^ (^act_cfg[i]);
  end

  assign rd_data = '0;
`endif

endmodule

// File: tb/tb_soc_system_clkdiv_multi.sv
// tb/tb_soc_system_clkdiv_multi.sv - directed self-checking bench for soc_system_clkdiv_multi
module tb_soc_system_clkdiv_multi;

  localparam int NC = 4;
  localparam int W  = 16;

  logic            refclk = 1'b0;
  logic            rst_n  = 1'b0;
  logic [NC-1:0]   outclk;
  logic            locked;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [3:0]      cfg_chan  = '0;
  logic [W-1:0]    cfg_hi    = '0;
  logic [W-1:0]    cfg_lo    = '0;
  logic [W-1:0]    cfg_prst  = '0;
  logic            cfg_en    = 1'b0;
  logic            cfg_err;
  logic [3:0]      rd_chan   = '0;
  logic [3*W:0]    rd_data;

  int errors = 0;
  int checks = 0;

  soc_system_clkdiv_multi #(
    .NUM_CLOCKS(NC), .CNT_W(W), .DEF_HI(13), .DEF_LO(12), .LOCK_CYCLES(64)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .outclk(outclk), .locked(locked),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .cfg_prst(cfg_prst), .cfg_en(cfg_en),
    .cfg_err(cfg_err), .rd_chan(rd_chan), .rd_data(rd_data)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rb(input logic en, input logic [15:0] prst,
                                     input logic [15:0] hi, input logic [15:0] lo);
`ifdef SOC_SYSTEM_CLKDIV_READBACK_EN
    return {15'b0, en, prst, hi, lo};
`else
    return 64'(en & 1'b0) | 64'(prst & 16'h0) | 64'(hi & 16'h0) | 64'(lo & 16'h0);
`endif
  endfunction

  task automatic send(input logic [3:0] ch, input logic [15:0] hi, input logic [15:0] lo,
                      input logic [15:0] prst, input logic en);
    int g = 0;
    while (!cfg_ready && g < 500) begin
      @(negedge refclk);
      g++;
    end
    if (!cfg_ready) chk("send_ready_timeout", 64'(cfg_ready), 64'd1);
    cfg_chan  = ch;
    cfg_hi    = hi;
    cfg_lo    = lo;
    cfg_prst  = prst;
    cfg_en    = en;
    cfg_valid = 1'b1;
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_locked(output int n);
    n = 0;
    while (!locked && n < 300) begin
      @(negedge refclk);
      n++;
    end
  endtask

  task automatic wait_relock(output int n);
    int g = 0;
    while (locked && g < 300) begin
      @(negedge refclk);
      g++;
    end
    wait_locked(n);
  endtask

  task automatic wait_rise(input int ch);
    logic prev;
    int   g = 0;
    prev = outclk[ch];
    @(negedge refclk);
    while (!(prev == 1'b0 && outclk[ch] == 1'b1) && g < 300) begin
      prev = outclk[ch];
      @(negedge refclk);
      g++;
    end
  endtask

  task automatic measure(input int ch, output int hi_n, output int lo_n);
    int g = 0;
    while (outclk[ch] == 1'b1 && g < 200) begin @(negedge refclk); g++; end
    while (outclk[ch] == 1'b0 && g < 400) begin @(negedge refclk); g++; end
    hi_n = 0;
    while (outclk[ch] == 1'b1 && hi_n < 200) begin @(negedge refclk); hi_n++; end
    lo_n = 0;
    while (outclk[ch] == 1'b0 && lo_n < 200) begin @(negedge refclk); lo_n++; end
  endtask

  initial begin
    int n, h, l, cnt;
    int m_ch1, m_ch0, m_ch2, m_ch3, m_lk, m_rdy;
    logic e_old, e1, el, er;

    // Reset state
    @(negedge refclk);
    chk("rst_outclk", 64'(outclk), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_ready", 64'(cfg_ready), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    rst_n = 1'b1;

    // Lock latency and default waveform
    wait_locked(n);
    chk("lock_latency", 64'(n), 64'd64);
    chk("lock_ready", 64'(cfg_ready), 64'd1);
    for (int c = 0; c < NC; c++) begin
      measure(c, h, l);
      chk($sformatf("def_hi_ch%0d", c), 64'(h), 64'd13);
      chk($sformatf("def_lo_ch%0d", c), 64'(l), 64'd12);
    end
    rd_chan = 4'd0;
    #1 chk("rb_default_ch0", 64'(rd_data), rb(1'b1, 16'd0, 16'd13, 16'd12));

    // Reconfigure channel 1 mid-period: hi=2, lo=3, prst=5
    wait_rise(1);
    chk("ch1_rise_found", 64'(outclk[1]), 64'd1);
    send(4'd1, 16'd2, 16'd3, 16'd5, 1'b1);
    m_ch1 = 0; m_ch0 = 0; m_ch2 = 0; m_ch3 = 0; m_lk = 0; m_rdy = 0;
    for (int k = 1; k <= 100; k++) begin
      e_old = ((k % 25) < 13);
      e1    = (k <= 12) ? 1'b1 : (k < 30) ? 1'b0 : (((k - 30) % 5) < 2);
      el    = (k <= 24) || (k >= 90);
      er    = (k >= 90);
      if (outclk[1] !== e1)    m_ch1++;
      if (outclk[0] !== e_old) m_ch0++;
      if (outclk[2] !== e_old) m_ch2++;
      if (outclk[3] !== e_old) m_ch3++;
      if (locked !== el)       m_lk++;
      if (cfg_ready !== er)    m_rdy++;
      @(negedge refclk);
    end
    chk("ch1_wave_mismatches", 64'(m_ch1), 64'd0);
    chk("ch0_undisturbed_mismatches", 64'(m_ch0), 64'd0);
    chk("ch2_undisturbed_mismatches", 64'(m_ch2), 64'd0);
    chk("ch3_undisturbed_mismatches", 64'(m_ch3), 64'd0);
    chk("relock_wave_mismatches", 64'(m_lk), 64'd0);
    chk("ready_wave_mismatches", 64'(m_rdy), 64'd0);
    measure(1, h, l);
    chk("ch1_new_hi", 64'(h), 64'd2);
    chk("ch1_new_lo", 64'(l), 64'd3);

    // Invalid channel index
    send(4'd9, 16'd1, 16'd1, 16'd0, 1'b1);
    chk("bad_chan_err", 64'(cfg_err), 64'd1);
    chk("bad_chan_locked", 64'(locked), 64'd1);
    chk("bad_chan_ready", 64'(cfg_ready), 64'd1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge refclk);
      cnt += int'(cfg_err);
      if (!locked || !cfg_ready) cnt += 100;
    end
    chk("bad_chan_err_single_pulse", 64'(cnt), 64'd0);
    measure(1, h, l);
    chk("bad_chan_ch1_hi", 64'(h), 64'd2);
    chk("bad_chan_ch1_lo", 64'(l), 64'd3);
    measure(0, h, l);
    chk("bad_chan_ch0_hi", 64'(h), 64'd13);
    rd_chan = 4'd1;
    #1 chk("rb_ch1", 64'(rd_data), rb(1'b1, 16'd5, 16'd2, 16'd3));

    // hi=0, lo=0 on channel 0 gives refclk/2
    send(4'd0, 16'd0, 16'd0, 16'd0, 1'b1);
    wait_relock(n);
    chk("ch0_relock_cycles", 64'(n), 64'd65);
    measure(0, h, l);
    chk("ch0_div2_hi", 64'(h), 64'd1);
    chk("ch0_div2_lo", 64'(l), 64'd1);

    // Disable channel 2
    send(4'd2, 16'd7, 16'd9, 16'd3, 1'b0);
    wait_relock(n);
    chk("ch2_relock_cycles", 64'(n), 64'd65);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      cnt += int'(outclk[2]);
      @(negedge refclk);
    end
    chk("ch2_disabled_high_count", 64'(cnt), 64'd0);
    rd_chan = 4'd2;
    #1 chk("rb_ch2", 64'(rd_data), rb(1'b0, 16'd3, 16'd7, 16'd9));
    rd_chan = 4'd12;
    #1 chk("rb_out_of_range", 64'(rd_data), 64'd0);

    // Reset while a request is pending
    @(negedge refclk);
    wait_rise(3);
    send(4'd3, 16'd4, 16'd4, 16'd0, 1'b1);
    chk("pend_ready", 64'(cfg_ready), 64'd0);
    chk("pend_locked", 64'(locked), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outclk", 64'(outclk), 64'd0);
    chk("async_rst_locked", 64'(locked), 64'd0);
    chk("async_rst_ready", 64'(cfg_ready), 64'd0);
    @(negedge refclk);
    rst_n = 1'b1;
    wait_locked(n);
    chk("rerst_lock_latency", 64'(n), 64'd64);
    measure(3, h, l);
    chk("rerst_ch3_hi", 64'(h), 64'd13);
    chk("rerst_ch3_lo", 64'(l), 64'd12);
    measure(2, h, l);
    chk("rerst_ch2_hi", 64'(h), 64'd13);
    rd_chan = 4'd3;
    #1 chk("rb_rerst_ch3", 64'(rd_data), rb(1'b1, 16'd0, 16'd13, 16'd12));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
